umem_dma: RTL

UMEM_DMA -- requirements
Module: umem_dma

---
 rtl/nopcpu_pkg.sv | 16 +
 rtl/umem_dma.sv | 125 ++++++++++++
 2 files changed

// File: rtl/nopcpu_pkg.sv
// Shared definitions for the user-memory DMA copy engine: default widths
// and the FSM state encoding.
package nopcpu_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/umem_dma.sv
// Byte-copy DMA over a shared user-memory bus. Each byte is one READ cycle
// (capture combinational read data) followed by one WRITE cycle. The bus is
// re-arbitrated whenever the grant is missing in REQ or READ.
module umem_dma
    import nopcpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic [ADDR_W-1:0] usermem_address,
    output logic [DATA_W-1:0] usermem_data_out,
    input  logic [DATA_W-1:0] usermem_data_in,
    output logic              rw
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] data_q, data_d;

    // State, pointers, byte count and data register; reset clears everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic; operands are only latched in IDLE, so a start pulse
    // during a copy cannot disturb it. Pointers wrap naturally at 2^ADDR_W.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        rem_d   = length;
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_REQ: begin
                if (bus_grant) state_d = S_READ;
            end
            S_READ: begin
                if (bus_grant) begin
                    data_d  = usermem_data_in;
                    state_d = S_WRITE;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WRITE: begin
                src_d = src_q + 1'b1;
                dst_d = dst_q + 1'b1;
                rem_d = rem_q - 1'b1;
                if (rem_q == ADDR_W'(1)) state_d = S_DONE;
                else if (bus_grant)      state_d = S_READ;
                else                     state_d = S_REQ;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus and status outputs decoded from state; the read address is only
    // driven while granted, the write cycle always owns the bus.
    always_comb begin
        busy             = 1'b0;
        done             = 1'b0;
        bus_req          = 1'b0;
        rw               = 1'b0;
        usermem_address  = '0;
        usermem_data_out = '0;
        unique case (state_q)
            S_REQ: begin
                busy    = 1'b1;
                bus_req = 1'b1;
            end
            S_READ: begin
                busy    = 1'b1;
                bus_req = 1'b1;
                if (bus_grant) usermem_address = src_q;
            end
            S_WRITE: begin
                busy             = 1'b1;
                bus_req          = 1'b1;
                rw               = 1'b1;
                usermem_address  = dst_q;
                usermem_data_out = data_q;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule
